// File: rtl/memarb_pkg.sv
// Shared definitions for the unified-memory arbiter: priority FSM encodings
// and the default geometry of the shared 2048 x 32 memory.
package memarb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_DPRI = 1'b0,
        ST_IPRI = 1'b1
    } pri_state_e;

endpackage

// File: rtl/m_memarb_pri.sv
// Priority FSM plus instruction starvation counter for m_memarb.
// Present only with MEMARB_FAIR_EN; otherwise w_ipri is tied to 0 (fixed data priority).
module m_memarb_pri
    import memarb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic w_clk,
    input  logic w_rst,
    input  logic w_ireq,
    input  logic w_istall,
    input  logic w_igrant,
    output logic w_ipri
);

`ifdef MEMARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    pri_state_e    state_reg;
    pri_state_e    state_next;
    logic [SW-1:0] r_starve;
    logic [SW-1:0] starve_next;

    always_comb begin
        starve_next = r_starve;
        state_next  = state_reg;

        if (w_igrant || !w_ireq) begin
            starve_next = '0;
        end else if (w_istall && (r_starve != STARVE_LIM)) begin
            starve_next = r_starve + 1'b1;
        end

        // Escalate on the denial that brings the count up to the limit, so the
        // instruction port wins the very next contested cycle.
        if (state_reg == ST_DPRI) begin
            if (w_istall && (starve_next == STARVE_LIM)) begin
                state_next = ST_IPRI;
            end
        end else begin
            if (w_igrant) begin
                state_next = ST_DPRI;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_reg <= ST_DPRI;
            r_starve  <= '0;
        end else begin
            state_reg <= state_next;
            r_starve  <= starve_next;
        end
    end

    assign w_ipri = (state_reg == ST_IPRI);
`else
    logic unused_pri_inputs;
    assign unused_pri_inputs = ^{w_clk, w_rst, w_ireq, w_istall, w_igrant, 32'(STARVE_MAX)};

    assign w_ipri = 1'b0;
`endif

endmodule

// File: rtl/m_memarb.sv
// Shares one single-port registered-read memory between instruction fetch and
// data access; one grant per cycle. Fairness via MEMARB_FAIR_EN (see m_memarb_pri).
module m_memarb
    import memarb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_ireq,
    input  logic [ADDR_W-1:0] w_iaddr,
    output logic              w_istall,
    output logic              r_ivalid,
    output logic [DATA_W-1:0] w_idata,
    input  logic              w_dreq,
    input  logic              w_dwe,
    input  logic [ADDR_W-1:0] w_daddr,
    input  logic [DATA_W-1:0] w_ddin,
    output logic              w_dstall,
    output logic              r_dvalid,
    output logic [DATA_W-1:0] w_ddata,
    output logic [ADDR_W-1:0] w_maddr,
    output logic              w_mwe,
    output logic [DATA_W-1:0] w_mdin,
    input  logic [DATA_W-1:0] w_mdout
);

    logic w_ipri;
    logic w_iwins;
    logic w_igrant;
    logic w_dgrant;

    // Data's grant is decided as if reset were low; reset only suppresses the
    // instruction grant so a store issued in the reset cycle still lands.
    assign w_iwins  = w_ireq & (~w_dreq | w_ipri);
    assign w_dgrant = w_dreq & ~w_iwins;
    assign w_igrant = w_iwins & ~w_rst;

    assign w_istall = w_ireq & ~w_igrant;
    assign w_dstall = w_dreq & ~w_dgrant;

    assign w_maddr = w_dgrant ? w_daddr : w_iaddr;
    assign w_mwe   = w_dgrant & w_dwe;
    assign w_mdin  = w_dgrant ? w_ddin : '0;

    assign w_idata = w_mdout;
    assign w_ddata = w_mdout;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            r_ivalid <= w_igrant;
            r_dvalid <= w_dgrant & ~w_dwe;
        end
    end

    m_memarb_pri #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pri (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_ireq   (w_ireq),
        .w_istall (w_istall),
        .w_igrant (w_igrant),
        .w_ipri   (w_ipri)
    );

endmodule

// File: tb/tb_m_memarb.sv
// Directed bench for m_memarb with a behavioural 2048 x 32 registered-read memory.
// Expectations adapt to whether MEMARB_FAIR_EN is defined.
module tb_m_memarb;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

`ifdef MEMARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              w_clk;
    logic              w_rst;
    logic              w_ireq;
    logic [ADDR_W-1:0] w_iaddr;
    logic              w_istall;
    logic              r_ivalid;
    logic [DATA_W-1:0] w_idata;
    logic              w_dreq;
    logic              w_dwe;
    logic [ADDR_W-1:0] w_daddr;
    logic [DATA_W-1:0] w_ddin;
    logic              w_dstall;
    logic              r_dvalid;
    logic [DATA_W-1:0] w_ddata;
    logic [ADDR_W-1:0] w_maddr;
    logic              w_mwe;
    logic [DATA_W-1:0] w_mdin;
    logic [DATA_W-1:0] w_mdout;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    m_memarb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (3)
    ) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_ireq   (w_ireq),
        .w_iaddr  (w_iaddr),
        .w_istall (w_istall),
        .r_ivalid (r_ivalid),
        .w_idata  (w_idata),
        .w_dreq   (w_dreq),
        .w_dwe    (w_dwe),
        .w_daddr  (w_daddr),
        .w_ddin   (w_ddin),
        .w_dstall (w_dstall),
        .r_dvalid (r_dvalid),
        .w_ddata  (w_ddata),
        .w_maddr  (w_maddr),
        .w_mwe    (w_mwe),
        .w_mdin   (w_mdin),
        .w_mdout  (w_mdout)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Read-before-write single-port memory with registered read.
    always @(posedge w_clk) begin
        if (w_mwe) mem[w_maddr] <= w_mdin;
        w_mdout <= mem[w_maddr];
    end

    task automatic test_reset();
        @(negedge w_clk);
        w_rst = 1'b1; w_ireq = 1'b1; w_iaddr = '0; w_dreq = 1'b0;
        #1;
        checks++;
        if (w_istall !== 1'b1) begin errors++; $display("FAIL reset_istall: got %b expected 1", w_istall); end
        checks++;
        if (w_dstall !== 1'b0) begin errors++; $display("FAIL reset_dstall: got %b expected 0", w_dstall); end
        @(posedge w_clk); #1;
        checks++;
        if (r_ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b expected 0", r_ivalid); end
        checks++;
        if (r_dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", r_dvalid); end
        $display("reset: istall/dstall/valids checked");
        @(negedge w_clk);
        w_rst = 1'b0; w_ireq = 1'b0;
    endtask

    task automatic test_ifetch();
        for (int a = 0; a < 4; a++) begin
            if (a != 0) @(negedge w_clk);
            w_ireq = 1'b1; w_iaddr = ADDR_W'(a); w_dreq = 1'b0;
            #1;
            checks++;
            if (w_istall !== 1'b0) begin errors++; $display("FAIL ifetch_istall[%0d]: got %b expected 0", a, w_istall); end
            checks++;
            if (w_maddr !== ADDR_W'(a) || w_mwe !== 1'b0) begin
                errors++; $display("FAIL ifetch_mem[%0d]: got addr=%0d we=%b expected addr=%0d we=0", a, w_maddr, w_mwe, a);
            end
            @(posedge w_clk); #1;
            checks++;
            if (r_ivalid !== 1'b1 || w_idata !== 32'h100 + 32'(a)) begin
                errors++; $display("FAIL ifetch_data[%0d]: got v=%b d=%h expected v=1 d=%h", a, r_ivalid, w_idata, 32'h100 + 32'(a));
            end
            $display("ifetch addr=%0d valid=%b data=%h", a, r_ivalid, w_idata);
        end
        @(negedge w_clk);
        w_ireq = 1'b0;
        @(posedge w_clk); #1;
        checks++;
        if (r_ivalid !== 1'b0) begin errors++; $display("FAIL ifetch_idle_ivalid: got %b expected 0", r_ivalid); end
    endtask

    task automatic test_write_read();
        @(negedge w_clk);
        w_dreq = 1'b1; w_dwe = 1'b1; w_daddr = 11'd5; w_ddin = 32'hDEADBEEF;
        #1;
        checks++;
        if (w_dstall !== 1'b0 || w_mwe !== 1'b1 || w_maddr !== 11'd5 || w_mdin !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_drive: got stall=%b we=%b addr=%0d din=%h expected 0 1 5 deadbeef", w_dstall, w_mwe, w_maddr, w_mdin);
        end
        @(posedge w_clk); #1;
        checks++;
        if (r_dvalid !== 1'b0) begin errors++; $display("FAIL wr_dvalid: got %b expected 0", r_dvalid); end
        $display("write addr=5 data=deadbeef dvalid=%b", r_dvalid);
        @(negedge w_clk);
        w_dwe = 1'b0; w_ddin = '0;
        #1;
        checks++;
        if (w_mwe !== 1'b0 || w_mdin !== 32'h0) begin errors++; $display("FAIL rd_drive: got we=%b din=%h expected 0 0", w_mwe, w_mdin); end
        @(posedge w_clk); #1;
        checks++;
        if (r_dvalid !== 1'b1 || w_ddata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data: got v=%b d=%h expected v=1 d=deadbeef", r_dvalid, w_ddata);
        end
        checks++;
        if (r_ivalid !== 1'b0) begin errors++; $display("FAIL rd_ivalid: got %b expected 0", r_ivalid); end
        $display("read addr=5 dvalid=%b data=%h", r_dvalid, w_ddata);
        @(negedge w_clk);
        w_dreq = 1'b0;
        @(posedge w_clk);
    endtask

    task automatic test_contention();
        int  istall_cnt = 0;
        bit  exp_i;
        @(negedge w_clk);
        w_ireq = 1'b1; w_iaddr = 11'd0; w_dreq = 1'b1; w_dwe = 1'b0; w_daddr = 11'd1;
        for (int k = 0; k < 20; k++) begin
            if (k != 0) @(negedge w_clk);
            exp_i = FAIR && ((k % 4) == 3);
            #1;
            if (w_istall === 1'b1) istall_cnt++;
            checks++;
            if (w_istall !== !exp_i) begin errors++; $display("FAIL cont_istall[%0d]: got %b expected %b", k, w_istall, !exp_i); end
            checks++;
            if (w_dstall !== exp_i) begin errors++; $display("FAIL cont_dstall[%0d]: got %b expected %b", k, w_dstall, exp_i); end
            @(posedge w_clk); #1;
            checks++;
            if (r_ivalid !== exp_i || (exp_i && w_idata !== 32'h100)) begin
                errors++; $display("FAIL cont_ivalid[%0d]: got v=%b d=%h expected v=%b d=00000100", k, r_ivalid, w_idata, exp_i);
            end
            checks++;
            if (r_dvalid !== !exp_i || (!exp_i && w_ddata !== 32'h101)) begin
                errors++; $display("FAIL cont_dvalid[%0d]: got v=%b d=%h expected v=%b d=00000101", k, r_dvalid, w_ddata, !exp_i);
            end
            $display("contention cycle=%0d grant=%s ivalid=%b dvalid=%b", k, exp_i ? "I" : "D", r_ivalid, r_dvalid);
        end
        checks++;
        if (istall_cnt != (FAIR ? 15 : 20)) begin
            errors++; $display("FAIL cont_istall_count: got %0d expected %0d", istall_cnt, FAIR ? 15 : 20);
        end
        @(negedge w_clk);
        w_ireq = 1'b0; w_dreq = 1'b0;
        @(posedge w_clk);
    endtask

    task automatic test_reset_midop();
        // A: instruction alone, granted
        @(negedge w_clk);
        w_ireq = 1'b1; w_iaddr = 11'd1; w_dreq = 1'b0;
        @(posedge w_clk); #1;
        checks++;
        if (r_ivalid !== 1'b1 || w_idata !== 32'h101) begin errors++; $display("FAIL mid_pre_ivalid: got v=%b d=%h expected v=1 d=00000101", r_ivalid, w_idata); end
        // A1: contested, data wins, starvation count becomes nonzero
        @(negedge w_clk);
        w_dreq = 1'b1; w_dwe = 1'b0; w_daddr = 11'd3;
        @(posedge w_clk); #1;
        checks++;
        if (r_dvalid !== 1'b1 || w_ddata !== 32'h103) begin errors++; $display("FAIL mid_pre_dvalid: got v=%b d=%h expected v=1 d=00000103", r_dvalid, w_ddata); end
        // B: reset while the instruction alone would be granted
        @(negedge w_clk);
        w_rst = 1'b1; w_dreq = 1'b0;
        #1;
        checks++;
        if (w_istall !== 1'b1) begin errors++; $display("FAIL mid_rst_istall: got %b expected 1", w_istall); end
        @(posedge w_clk); #1;
        checks++;
        if (r_ivalid !== 1'b0) begin errors++; $display("FAIL mid_rst_ivalid: got %b expected 0", r_ivalid); end
`ifdef MEMARB_FAIR_EN
        checks++;
        if (dut.u_pri.r_starve !== 2'd0) begin errors++; $display("FAIL mid_rst_starve: got %0d expected 0", dut.u_pri.r_starve); end
`endif
        $display("reset mid-op: ivalid=%b", r_ivalid);
        // C, D: dual requests after reset both go to data
        for (int c = 0; c < 2; c++) begin
            @(negedge w_clk);
            w_rst = 1'b0; w_dreq = 1'b1;
            #1;
            checks++;
            if (w_dstall !== 1'b0 || w_istall !== 1'b1) begin
                errors++; $display("FAIL mid_post_grant[%0d]: got istall=%b dstall=%b expected 1 0", c, w_istall, w_dstall);
            end
            @(posedge w_clk); #1;
            checks++;
            if (r_dvalid !== 1'b1 || r_ivalid !== 1'b0 || w_ddata !== 32'h103) begin
                errors++; $display("FAIL mid_post_data[%0d]: got dv=%b iv=%b d=%h expected 1 0 00000103", c, r_dvalid, r_ivalid, w_ddata);
            end
            $display("post-reset dual request %0d: dvalid=%b ivalid=%b", c, r_dvalid, r_ivalid);
        end
        @(negedge w_clk);
        w_ireq = 1'b0; w_dreq = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h100 + 32'(i);
        w_rst = 1'b1; w_ireq = 1'b0; w_iaddr = '0;
        w_dreq = 1'b0; w_dwe = 1'b0; w_daddr = '0; w_ddin = '0;

        test_reset();
        test_ifetch();
        test_write_read();
        test_contention();
        test_reset_midop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_memarb.md
# m_memarb

Two-port arbiter that shares one single-port synchronous memory (2048 x 32, write-on-clock, registered read) between the instruction-fetch port and the data-access port of the pipelined processor. This lets the processor run from a unified instruction/data memory. Each cycle the block grants at most one requester, drives the memory address, write-enable and write-data, and steers the one-cycle-late read data back with a per-port valid. The losing port receives a stall that the pipeline uses the way it uses an interlock.

## Interface
Parameters:
- ADDR_W, 11, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, data width
- STARVE_MAX, 3, consecutive denied instruction requests before the instruction port is forced to priority (FAIR mode only)

Ports:
- w_clk  in  1  clock; all state updates on posedge
- w_rst  in  1  reset, synchronous, active-high
- w_ireq  in  1  instruction read request
- w_iaddr  in  ADDR_W  instruction word address
- w_istall  out  1  instruction request not granted this cycle (combinational)
- r_ivalid  out  1  w_idata holds the instruction granted last cycle
- w_idata  out  DATA_W  instruction read data (w_mdout pass-through)
- w_dreq  in  1  data request
- w_dwe  in  1  data request is a write
- w_daddr  in  ADDR_W  data word address
- w_ddin  in  DATA_W  store data
- w_dstall  out  1  data request not granted this cycle (combinational)
- r_dvalid  out  1  w_ddata holds the load granted last cycle (never set for writes)
- w_ddata  out  DATA_W  load data (w_mdout pass-through)
- w_maddr  out  ADDR_W  memory address
- w_mwe  out  1  memory write-enable
- w_mdin  out  DATA_W  memory write data
- w_mdout  in  DATA_W  memory registered read data

## Operation
- Grant is computed combinationally each cycle from the requests and the registered state: `w_igrant`, `w_dgrant`, at most one of them high.
- Memory drive:
  - If `w_dgrant`: `w_maddr=w_daddr`, `w_mwe=w_dwe`, `w_mdin=w_ddin`.
  - Else: `w_maddr=w_iaddr`, `w_mwe=0`, `w_mdin=0`.
- Stalls: `w_istall = w_ireq & ~w_igrant`; `w_dstall = w_dreq & ~w_dgrant`.
- A granted port presents its next request, or drops `req`, in the following cycle. A stalled port holds `addr`, `we` and `din` stable until granted.
- Priority FSM has two states, with reset state `ST_DPRI`:
  - `ST_DPRI`: data wins when both ports request.
  - `ST_IPRI`: instruction wins when both ports request. After the next instruction grant the FSM returns to `ST_DPRI`.
  - Transition `ST_DPRI->ST_IPRI` happens when `r_starve` reaches STARVE_MAX on an instruction denial.
- Starvation counter `r_starve`, width `$clog2(STARVE_MAX+1)`:
  - Increments on each cycle with `w_istall`.
  - Clears on an instruction grant or when `w_ireq=0`.
  - Saturates at STARVE_MAX.
- Single requester: that requester is granted regardless of FSM state.
- Read return: `r_ivalid <= w_igrant`; `r_dvalid <= w_dgrant & ~w_dwe`. The `w_idata`/`w_ddata` values are meaningful only while the matching valid is high.
- Same-address write then read in consecutive cycles: the read returns the new data.
- Same-cycle read-during-write is impossible, since the block grants only one port per cycle.
- Reset, including mid-operation: `r_ivalid=0`, `r_dvalid=0`, `r_starve=0`, FSM to `ST_DPRI`. Any read in flight is discarded. A write granted in the reset cycle is still performed, because memory is not reset.

## Timing
- Grant-to-data latency is 1 cycle: request granted at edge N, valid and data at edge N+1.
- Throughput is one access per cycle total.
- Stall outputs are combinational from `req` and state, with no added register.
- Reset values: `r_ivalid=0`, `r_dvalid=0`, `w_istall=w_ireq`, `w_dstall=0`.
- While `w_rst` is high, `w_igrant` is forced to 0 and `w_dgrant` follows the normal rules.

## Configuration
- `MEMARB_FAIR_EN` defined: the starvation counter and `ST_IPRI` are present, as described above.
- Not defined: fixed data priority. The counter and FSM are removed, and the instruction port waits indefinitely while `w_dreq` is held.

## Structure
- Shared package `memarb_pkg` holds:
  - the FSM state encodings `ST_DPRI`=1'b0 and `ST_IPRI`=1'b1;
  - the default ADDR_W and DATA_W constants.
- One natural sub-module, `m_memarb_pri`: the priority FSM plus starvation counter.
  - Inputs: `w_clk`, `w_rst`, `w_ireq`, `w_istall`, `w_igrant`.
  - Output: `w_ipri`.
  - Compiled out to a constant 0 without `MEMARB_FAIR_EN`.

## Test plan
- Instruction-only reads of addresses 0..3, memory preloaded with 0x100+addr:
  - required: no stalls;
  - required: `r_ivalid` high from cycle 1, returning 0x100..0x103 one per cycle.
- Write 0xDEADBEEF to address 5, then a data read of address 5 in the next cycle:
  - required: `r_dvalid=0` after the write;
  - required: `r_dvalid=1`, `w_ddata`=0xDEADBEEF after the read.
- `w_ireq` and `w_dreq` held continuously, FAIR, STARVE_MAX=3:
  - required: grant pattern D,D,D,I repeating;
  - required: `w_istall` high exactly 3 of every 4 cycles.
- Same stimulus with the macro undefined:
  - required: `w_istall` stays high for 20 cycles;
  - required: `r_ivalid` never set.
- Reset asserted for 1 cycle while an instruction read is granted:
  - required: `r_ivalid=0` in the following cycle;
  - required: `r_starve=0`;
  - required: the next dual request is granted to data.
